// File: rtl/pmm_pkg.sv
// Shared types and constants for the pattern-matching-module scheduler.
package pmm_pkg;

  localparam int N_PMM = 4;
  localparam int LEN_W = 16;
  localparam int UID_W = 2;
  localparam int RES_W = UID_W + LEN_W;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ISSUE   = 2'd2,
    S_COLLECT = 2'd3
  } pmm_state_e;

  typedef struct packed {
    logic [UID_W-1:0] unit_id;
    logic [LEN_W-1:0] offset;
  } pmm_res_t;

endpackage

// File: rtl/pmm_res_fifo.sv
// Synchronous result FIFO; head reads as zero while empty.
module pmm_res_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  // Fullness is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pmm_scheduler.sv
// Broadcasts text bytes to the enabled PMMs and funnels their matches into a result FIFO.
// Optional per-unit match counters are built when PMM_MATCH_CNT_EN is defined.
module pmm_scheduler
  import pmm_pkg::*;
#(
  parameter int RES_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic [N_PMM-1:0]          cfg_enable,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic [N_PMM-1:0]          pmm_valid,
  output logic [7:0]                pmm_byte,
  input  logic [N_PMM-1:0]          pmm_ack,
  input  logic [N_PMM-1:0]          pmm_match,
  input  logic                      res_pop,
  output logic                      res_valid,
  output logic [RES_W-1:0]          res_data,
  output logic                      busy,
  output logic                      done,
`ifdef PMM_MATCH_CNT_EN
  output logic [N_PMM*CNT_W-1:0]    match_cnt,
`endif
  output logic [1:0]                dbg_state_o,
  output logic [$clog2(RES_DEPTH):0] dbg_count_o
);

  // Handshakes: a text byte moves when in_valid && in_ready in the same cycle;
  // a result leaves the FIFO when res_pop && res_valid in the same cycle.

  pmm_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic [N_PMM-1:0]  en_q, en_d;
  logic [N_PMM-1:0]  ack_seen_q, ack_seen_d;
  logic [N_PMM-1:0]  pend_q, pend_d;
  logic [N_PMM-1:0]  pvalid_q, pvalid_d;
  logic [7:0]        byte_q, byte_d;
  logic [UID_W-1:0]  rr_q, rr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [N_PMM-1:0]  acks;
  logic              grant_vld;
  logic [UID_W-1:0]  grant;
  logic              push;
  pmm_res_t          push_data;
  logic              fifo_full, fifo_empty;

  assign acks        = pmm_ack & en_q;
  assign in_ready    = (state_q == S_FETCH) && !abort;
  assign pmm_valid   = pvalid_q;
  assign pmm_byte    = byte_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_valid   = !fifo_empty;
  assign dbg_state_o = state_q;

  // Round-robin: first pending unit at or after rr, wrapping through the 2-bit index.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < N_PMM; k++) begin
      if (!grant_vld && pend_q[rr_q + UID_W'(k)]) begin
        grant_vld = 1'b1;
        grant     = rr_q + UID_W'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    off_d      = off_q;
    en_d       = en_q;
    ack_seen_d = ack_seen_q;
    pend_d     = pend_q;
    pvalid_d   = pvalid_q;
    byte_d     = byte_q;
    rr_d       = rr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    push       = 1'b0;
    push_data  = '0;

    if (abort) begin
      state_d    = S_IDLE;
      pend_d     = '0;
      ack_seen_d = '0;
      pvalid_d   = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_len != '0) begin
              state_d = S_FETCH;
              len_d   = cfg_len;
              en_d    = cfg_enable;
              off_d   = '0;
              busy_d  = 1'b1;
            end else begin
              done_d  = 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            byte_d     = in_data;
            pvalid_d   = en_q;
            ack_seen_d = '0;
            pend_d     = '0;
            state_d    = (en_q == '0) ? S_COLLECT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          ack_seen_d = ack_seen_q | acks;
          pend_d     = pend_q | (acks & pmm_match);
          pvalid_d   = pvalid_q & ~acks;
          if ((ack_seen_q | acks) == en_q) state_d = S_COLLECT;
        end
        S_COLLECT: begin
          if (pend_q != '0) begin
            if (!fifo_full && grant_vld) begin
              push              = 1'b1;
              push_data.unit_id = grant;
              push_data.offset  = off_q;
              pend_d[grant]     = 1'b0;
              rr_d              = grant + UID_W'(1);
            end
          end else if (off_q == len_q - LEN_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            off_d   = off_q + LEN_W'(1);
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      off_q      <= '0;
      en_q       <= '0;
      ack_seen_q <= '0;
      pend_q     <= '0;
      pvalid_q   <= '0;
      byte_q     <= '0;
      rr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      off_q      <= off_d;
      en_q       <= en_d;
      ack_seen_q <= ack_seen_d;
      pend_q     <= pend_d;
      pvalid_q   <= pvalid_d;
      byte_q     <= byte_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  pmm_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (res_pop),
    .head      (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (dbg_count_o)
  );

`ifdef PMM_MATCH_CNT_EN
  logic [N_PMM-1:0][CNT_W-1:0] cnt_q;
  logic                        start_acc;

  assign start_acc = start && !abort && (state_q == S_IDLE);
  assign match_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_acc) begin
      cnt_q <= '0;
    end else if (push && (cnt_q[grant] != {CNT_W{1'b1}})) begin
      cnt_q[grant] <= cnt_q[grant] + CNT_W'(1);
    end
  end
`endif

endmodule
